// File: rtl/img_cap_wr_ctrl.sv
// Camera byte-stream capture to RAM write port 0: RGB565 pairs -> RGB888 words at sequential addresses.
// Latency: second byte of a pixel at cycle N -> wr_en at N+1 when the pixel FIFO was empty.
// Backpressure: wr_rdy stalls the FIFO head; a pixel arriving at a full FIFO is dropped and flagged.
//
// Ports:
//   CLOCK_125_p, reset (async, active-low)
//   cap_en                      capture arm request
//   vsync, href, pix_valid,     synchronized camera framing and byte stream
//   pix_byte
//   wr_rdy / wr_en, wr_addr,    RAM write handshake, word address, {8'h00,R8,G8,B8}
//   wr_data
//   busy, frame_done,           status: active, end-of-frame pulse,
//   frame_err, overflow         sticky short-frame flag, sticky pixel-drop flag
module img_cap_wr_ctrl #(
  parameter logic [23:0] BASE_ADDR    = 24'h000000,
  parameter logic [23:0] FRAME_PIXELS = 24'd307200,
  parameter int          FIFO_DEPTH   = 16,
  parameter bit          CONTINUOUS   = 1'b0
) (
  input  logic        CLOCK_125_p,
  input  logic        reset,
  input  logic        cap_en,
  input  logic        vsync,
  input  logic        href,
  input  logic        pix_valid,
  input  logic [7:0]  pix_byte,
  input  logic        wr_rdy,
  output logic        wr_en,
  output logic [23:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_FLUSH} state_t;

  state_t      state_q;
  logic        cap_en_q, vsync_q, href_q;
  logic        phase_q;
  logic [7:0]  hi_q;
  logic [23:0] pix_cnt_q;
  logic [23:0] wr_addr_q;
  logic        frame_done_q, frame_err_q, overflow_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   fcnt_q;

  // Pixel storage plus a per-entry skip count: the number of pixels dropped
  // immediately after this entry. Popping an entry advances the address past
  // itself and its dropped successors, so addresses track pixel position.
  logic [23:0] mem_pix_q  [FIFO_DEPTH];
  logic [23:0] mem_skip_q [FIFO_DEPTH];

  logic        byte_acc, pix_fire, push, pop, drop, last_pix;
  logic        fifo_empty, fifo_full;
  logic        vs_rise, vs_fall, href_fall, arm_req;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;
  logic [23:0] pix_rgb;
  logic [23:0] head_pix, head_skip;

  always_comb begin
    fifo_empty = (fcnt_q == '0);
    fifo_full  = (fcnt_q == FULL_CNT);
    byte_acc   = (state_q == ST_CAPTURE) && pix_valid && href;
    pix_fire   = byte_acc && phase_q;
    pop        = !fifo_empty && wr_rdy;
    // A full FIFO that pops this cycle still has room for the new pixel.
    push       = pix_fire && (!fifo_full || pop);
    drop       = pix_fire && fifo_full && !pop;
    last_pix   = pix_fire && (pix_cnt_q == FRAME_PIXELS - 24'd1);
    vs_rise    = vsync && !vsync_q;
    vs_fall    = !vsync && vsync_q;
    href_fall  = href_q && !href;
    arm_req    = CONTINUOUS ? cap_en : (cap_en && !cap_en_q);

    r5      = hi_q[7:3];
    g6      = {hi_q[2:0], pix_byte[7:5]};
    b5      = pix_byte[4:0];
    pix_rgb = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

    head_pix  = mem_pix_q[rd_ptr_q];
    head_skip = mem_skip_q[rd_ptr_q];
  end

  assign wr_en      = !fifo_empty;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = fifo_empty ? 32'h0 : {8'h00, head_pix};
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

  // Storage needs no reset: the pointers define validity and wr_data is
  // masked while empty.
  always_ff @(posedge CLOCK_125_p) begin
    if (push) begin
      mem_pix_q[wr_ptr_q]  <= pix_rgb;
      mem_skip_q[wr_ptr_q] <= 24'd0;
    end
    // Drops only happen when full without a pop, so the newest entry is
    // never the one being popped.
    if (drop) begin
      mem_skip_q[wr_ptr_q - AW'(1)] <= mem_skip_q[wr_ptr_q - AW'(1)] + 24'd1;
    end
  end

  always_ff @(posedge CLOCK_125_p or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cap_en_q     <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= 8'h00;
      pix_cnt_q    <= 24'd0;
      wr_addr_q    <= BASE_ADDR;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fcnt_q       <= '0;
    end else begin
      cap_en_q     <= cap_en;
      vsync_q      <= vsync;
      href_q       <= href;
      frame_done_q <= 1'b0;

      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        wr_addr_q <= wr_addr_q + 24'd1 + head_skip;
      end
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
      if (drop) overflow_q <= 1'b1;

      // An odd trailing byte at end of line is discarded by the phase reset.
      if (href_fall) begin
        phase_q <= 1'b0;
      end else if (byte_acc) begin
        phase_q <= ~phase_q;
        if (!phase_q) hi_q <= pix_byte;
      end
      // Dropped pixels still count so later pixels keep their positions.
      if (pix_fire) pix_cnt_q <= pix_cnt_q + 24'd1;

      case (state_q)
        ST_IDLE: begin
          if (arm_req) begin
            state_q     <= ST_ARMED;
            frame_err_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          // Wait for a fresh frame start; a frame already running is skipped.
          if (vs_fall) begin
            state_q   <= ST_CAPTURE;
            pix_cnt_q <= 24'd0;
            phase_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
          end
        end
        ST_CAPTURE: begin
          if (last_pix) begin
            state_q <= ST_FLUSH;
          end else if (vs_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty) begin
            frame_done_q <= 1'b1;
            if (CONTINUOUS && cap_en) begin
              state_q     <= ST_ARMED;
              frame_err_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_cap_wr_ctrl.sv
module tb_img_cap_wr_ctrl;

  localparam logic [23:0] BASE = 24'hFFFFFC;

  logic        clk = 1'b0;
  logic        reset, cap_en, vsync, href, pix_valid, wr_rdy;
  logic [7:0]  pix_byte;
  logic        wr_en, busy, frame_done, frame_err, overflow;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int idx      = 0;
  logic [55:0] exp_q[$];

  always #5 clk = ~clk;

  img_cap_wr_ctrl #(
    .BASE_ADDR(BASE), .FRAME_PIXELS(24'd8), .FIFO_DEPTH(4), .CONTINUOUS(1'b0)
  ) dut (
    .CLOCK_125_p(clk), .reset(reset), .cap_en(cap_en), .vsync(vsync), .href(href),
    .pix_valid(pix_valid), .pix_byte(pix_byte), .wr_rdy(wr_rdy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // RGB565 -> RGB888 by shifting each channel up and refilling the low bits
  // with the channel's most significant bits.
  function automatic logic [31:0] rgb(input logic [15:0] p);
    logic [7:0] r, g, b;
    r = {3'b0, p[15:11]};
    g = {2'b0, p[10:5]};
    b = {3'b0, p[4:0]};
    return {8'h00, 8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // Every accepted write must be the next expected (address, data) pair.
  initial begin
    logic [55:0] e;
    forever begin
      @(negedge clk);
      if (reset && wr_en && wr_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {8'h00, wr_addr}, {8'h00, e[55:32]});
          check("wr_data", wr_data, e[31:0]);
        end
      end
      if (frame_done) begin
        done_cnt++;
        check("done_after_all_writes", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [31:0] exp_d, input bit wr, input bit lat);
    if (wr) exp_q.push_back({BASE + 24'(idx), exp_d});
    idx++;
    pix_byte = hi; pix_valid = 1'b1; tick();
    pix_valid = 1'b0; tick();
    pix_byte = lo; pix_valid = 1'b1; tick();
    pix_valid = 1'b0;
    if (lat) check("latency_wr_en", {31'd0, wr_en}, 32'd1);
    tick();
  endtask

  task automatic start_frame();
    idx = 0;
    cap_en = 1'b1; tick();
    cap_en = 1'b0; vsync = 1'b0; tick();
    href = 1'b1;
  endtask

  task automatic end_short();
    href = 1'b0; vsync = 1'b1; tick();
  endtask

  task automatic wait_idle_and_check(input string name, input int done_req,
                                     input bit err_req, input bit ovf_req);
    int n = 0;
    href = 1'b0; vsync = 1'b1;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
    repeat (2) @(negedge clk);
    check({name, "_frame_done_count"}, 32'(done_cnt), 32'(done_req));
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frame_err"}, {31'd0, frame_err}, {31'd0, err_req});
    check({name, "_overflow"}, {31'd0, overflow}, {31'd0, ovf_req});
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; cap_en = 1'b0; vsync = 1'b1; href = 1'b0;
    pix_valid = 1'b0; pix_byte = 8'h00; wr_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {8'h00, wr_addr}, {8'h00, BASE});
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("model_pin_1234", rgb(16'h1234), 32'h001045A5);
    check("model_pin_07E0", rgb(16'h07E0), 32'h0000FF00);
    tick();
    reset = 1'b1;
    tick();

    // Primary colours, then vsync rises early: short frame.
    start_frame();
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_pixel(8'hF8, 8'h00, 32'h00FF0000, 1'b1, 1'b1);
    send_pixel(8'h07, 8'hE0, 32'h0000FF00, 1'b1, 1'b0);
    send_pixel(8'h00, 8'h1F, 32'h000000FF, 1'b1, 1'b0);
    send_pixel(8'hFF, 8'hFF, 32'h00FFFFFF, 1'b1, 1'b0);
    end_short();
    wait_idle_and_check("t1", 1, 1'b1, 1'b0);

    // Full 8-pixel frame under intermittent backpressure; addresses wrap past FFFFFF.
    start_frame();
    check("t2_frame_err_cleared", {31'd0, frame_err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] p;
      p = 16'h1234 + 16'(i * 16'h2345);
      wr_rdy = (i % 3) != 0;
      send_pixel(p[15:8], p[7:0], rgb(p), 1'b1, 1'b0);
    end
    wr_rdy = 1'b1;
    wait_idle_and_check("t2", 2, 1'b0, 1'b0);

    // Odd byte count on a line: trailing byte dropped, next line starts fresh.
    start_frame();
    send_pixel(8'hA5, 8'h3C, rgb(16'hA53C), 1'b1, 1'b0);
    pix_byte = 8'h77; pix_valid = 1'b1; tick();
    pix_valid = 1'b0; href = 1'b0; tick();
    tick();
    href = 1'b1;
    send_pixel(8'h5A, 8'hC3, rgb(16'h5AC3), 1'b1, 1'b0);
    end_short();
    wait_idle_and_check("t4", 3, 1'b1, 1'b0);

    // Armed while a frame is already active: that frame is ignored.
    vsync = 1'b0; tick();
    cap_en = 1'b1; tick();
    cap_en = 1'b0; href = 1'b1;
    check("t6_armed_busy", {31'd0, busy}, 32'd1);
    send_pixel(8'h11, 8'h22, 32'd0, 1'b0, 1'b0);
    send_pixel(8'h33, 8'h44, 32'd0, 1'b0, 1'b0);
    href = 1'b0; vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
    href = 1'b1; idx = 0;
    send_pixel(8'h9C, 8'h61, rgb(16'h9C61), 1'b1, 1'b0);
    end_short();
    wait_idle_and_check("t6", 4, 1'b1, 1'b0);

    // Overflow: pixels 4 and 5 dropped, pixels 6 and 7 keep their addresses.
    start_frame();
    wr_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [15:0] p;
      p = 16'h0F0F + 16'(i * 16'h1357);
      send_pixel(p[15:8], p[7:0], rgb(p), i < 4, 1'b0);
    end
    check("t3_overflow_set", {31'd0, overflow}, 32'd1);
    check("t3_no_early_done", 32'(done_cnt), 32'd4);
    wr_rdy = 1'b1;
    send_pixel(8'hC0, 8'hDE, rgb(16'hC0DE), 1'b1, 1'b0);
    send_pixel(8'hBE, 8'hEF, rgb(16'hBEEF), 1'b1, 1'b0);
    wait_idle_and_check("t3", 5, 1'b0, 1'b1);

    // Reset in the middle of a capture with pixels buffered.
    start_frame();
    wr_rdy = 1'b0;
    send_pixel(8'h12, 8'h34, 32'd0, 1'b0, 1'b0);
    send_pixel(8'h56, 8'h78, 32'd0, 1'b0, 1'b0);
    send_pixel(8'h9A, 8'hBC, 32'd0, 1'b0, 1'b0);
    check("t5_pre_wr_en", {31'd0, wr_en}, 32'd1);
    reset = 1'b0;
    #2;
    check("t5_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("t5_rst_wr_addr", {8'h00, wr_addr}, {8'h00, BASE});
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("t5_rst_overflow", {31'd0, overflow}, 32'd0);
    href = 1'b0; vsync = 1'b1; wr_rdy = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    start_frame();
    send_pixel(8'h84, 8'h10, rgb(16'h8410), 1'b1, 1'b0);
    end_short();
    wait_idle_and_check("t5_after", 6, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
